// File: rtl/ro_puf_pkg.sv
// Shared types and constants for the serial RO-PUF measurement engine.
package ro_puf_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StMeasure,
    StDrain,
    StCompare,
    StDone
  } state_e;

  // Flops in each RO input synchroniser.
  localparam int unsigned SYNC_DEPTH = 2;
  // Cycles counting continues after the window, so edges already in the synchroniser still land.
  localparam int unsigned DRAIN_CYCLES = 2;

endpackage

// File: rtl/ro_puf_serial_engine_if.sv
// Host-side start/done/ack handshake bundle for the RO-PUF engine.
interface ro_puf_serial_engine_if #(
  parameter int unsigned CHAL_W = 8,
  parameter int unsigned RESP_W = 8
);
  logic              start;
  logic [CHAL_W-1:0] challenge;
  logic              ack;
  logic              busy;
  logic              done;
  logic [RESP_W-1:0] response;
  logic              sat;

  modport master (output start, challenge, ack, input busy, done, response, sat);
  modport slave  (input start, challenge, ack, output busy, done, response, sat);
endinterface

// File: rtl/ro_edge_counter.sv
// Synchronises one asynchronous RO output, detects rising edges and counts them while enabled.
// The count saturates at all-ones; sat_o reflects that the counter sits at its maximum.
module ro_edge_counter
  import ro_puf_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ro_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             sat_o
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  prev_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rise;

  assign rise  = sync_q[SYNC_DEPTH-1] & ~prev_q;
  assign sat_o = &cnt_q;
  assign cnt_o = cnt_q;

  // Synchroniser chain plus edge-detect history; runs continuously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], ro_i};
      prev_q <= sync_q[SYNC_DEPTH-1];
    end
  end

  // Next count: clear wins, then saturating increment on a synchronised rising edge.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && rise && !sat_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ro_puf_serial_engine.sv
// Serial RO-PUF measurement engine: latches a challenge, walks RESP_W oscillator pairs, counts
// edges of each pair over a fixed window and builds the response bit by bit.
// Optional feature macro: PUF_MAJORITY_EN (each bit is a majority over VOTES measurements).
module ro_puf_serial_engine
  import ro_puf_pkg::*;
#(
  parameter int unsigned CHAL_W        = 8,
  parameter int unsigned RESP_W        = 8,
  parameter int unsigned NUM_RO        = 32,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned WINDOW_CYCLES = 1024,
  parameter int unsigned VOTES         = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  ro_puf_serial_engine_if.slave     host,
  input  logic                      ro_a_in,
  input  logic                      ro_b_in,
  output logic                      ro_en,
  output logic [$clog2(NUM_RO)-1:0] ro_sel_a,
  output logic [$clog2(NUM_RO)-1:0] ro_sel_b
);

  localparam int unsigned SEL_W   = $clog2(NUM_RO);
  localparam int unsigned IDX_W   = (RESP_W > 1) ? $clog2(RESP_W) : 1;
  localparam int unsigned TMR_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  // Elaboration-time parameter legality; VOTES is checked even when the vote logic is absent.
  if (CHAL_W < SEL_W || NUM_RO < 4 || (NUM_RO & (NUM_RO - 1)) != 0) begin : g_bad_ro_params
    $error("ro_puf_serial_engine: illegal CHAL_W/NUM_RO");
  end
  if (VOTES < 3 || (VOTES % 2) == 0 || SETTLE_CYCLES < 1 || WINDOW_CYCLES < 1) begin : g_bad_params
    $error("ro_puf_serial_engine: illegal VOTES/SETTLE_CYCLES/WINDOW_CYCLES");
  end

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SEL_W-1:0]  c_q, c_d;
  logic [SEL_W-1:0]  sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic [RESP_W-1:0] resp_q, resp_d;
  logic              sat_q, sat_d;
  logic              load_sel;
  logic              meas_bit;
  logic              cnt_clr, cnt_en;
  logic [CNT_W-1:0]  cnt_a, cnt_b;
  logic              sat_a, sat_b;

`ifdef PUF_MAJORITY_EN
  localparam int unsigned V_W  = $clog2(VOTES);
  localparam int unsigned VC_W = $clog2(VOTES + 1);
  logic [V_W-1:0]  vote_q, vote_d;
  logic [VC_W-1:0] ones_q, ones_d, ones_n;
`endif

  assign meas_bit = (cnt_a > cnt_b);
  assign cnt_clr  = (state_q == StIdle) || (state_q == StSettle);
  assign cnt_en   = (state_q == StMeasure) || (state_q == StDrain);

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk   (clk),
    .rst   (rst),
    .ro_i  (ro_a_in),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (cnt_a),
    .sat_o (sat_a)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk   (clk),
    .rst   (rst),
    .ro_i  (ro_b_in),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (cnt_b),
    .sat_o (sat_b)
  );

  // Next-state, timer, bit index and response assembly.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    idx_d    = idx_q;
    c_d      = c_q;
    resp_d   = resp_q;
    sat_d    = sat_q;
    load_sel = 1'b0;
`ifdef PUF_MAJORITY_EN
    vote_d   = vote_q;
    ones_d   = ones_q;
    ones_n   = ones_q + VC_W'(meas_bit);
`endif
    unique case (state_q)
      StIdle: begin
        if (host.start) begin
          c_d      = host.challenge[SEL_W-1:0];
          resp_d   = '0;
          sat_d    = 1'b0;
          idx_d    = '0;
          tmr_d    = '0;
          load_sel = 1'b1;
`ifdef PUF_MAJORITY_EN
          vote_d   = '0;
          ones_d   = '0;
`endif
          state_d  = StSettle;
        end
      end
      StSettle: begin
        if (tmr_q == TMR_W'(SETTLE_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = StMeasure;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      StMeasure: begin
        if (tmr_q == TMR_W'(WINDOW_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = StDrain;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      StDrain: begin
        if (tmr_q == TMR_W'(DRAIN_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = StCompare;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      StCompare: begin
        sat_d   = sat_q | sat_a | sat_b;
        state_d = StSettle;
`ifdef PUF_MAJORITY_EN
        if (vote_q == V_W'(VOTES - 1)) begin
          resp_d[idx_q] = (ones_n > VC_W'(VOTES / 2));
          vote_d        = '0;
          ones_d        = '0;
          if (idx_q == IDX_W'(RESP_W - 1)) begin
            state_d = StDone;
          end else begin
            idx_d    = idx_q + IDX_W'(1);
            load_sel = 1'b1;
          end
        end else begin
          vote_d = vote_q + V_W'(1);
          ones_d = ones_n;
        end
`else
        resp_d[idx_q] = meas_bit;
        if (idx_q == IDX_W'(RESP_W - 1)) begin
          state_d = StDone;
        end else begin
          idx_d    = idx_q + IDX_W'(1);
          load_sel = 1'b1;
        end
`endif
      end
      StDone: begin
        if (host.ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pair selects are registered so they stay put from SETTLE entry until the next pair.
  always_comb begin
    sel_a_d = sel_a_q;
    sel_b_d = sel_b_q;
    if (load_sel) begin
      sel_a_d = c_d + SEL_W'({idx_d, 1'b0});
      sel_b_d = sel_a_d + SEL_W'(1);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      tmr_q   <= '0;
      idx_q   <= '0;
      c_q     <= '0;
      sel_a_q <= '0;
      sel_b_q <= '0;
      resp_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
      resp_q  <= resp_d;
      sat_q   <= sat_d;
    end
  end

`ifdef PUF_MAJORITY_EN
  // Vote index and running count of '1' votes for the current bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vote_q <= '0;
      ones_q <= '0;
    end else begin
      vote_q <= vote_d;
      ones_q <= ones_d;
    end
  end
`endif

  assign ro_en         = (state_q == StSettle) || (state_q == StMeasure) || (state_q == StDrain);
  assign ro_sel_a      = sel_a_q;
  assign ro_sel_b      = sel_b_q;
  assign host.busy     = (state_q != StIdle);
  assign host.done     = (state_q == StDone);
  assign host.response = resp_q;
  assign host.sat      = sat_q;

endmodule

// File: tb/tb_ro_puf_serial_engine.sv
// Scoreboard bench for ro_puf_serial_engine: drivers push expected selects/results into queues,
// monitors pop and compare when the DUT raises ro_en or done.
module tb_ro_puf_serial_engine;

  localparam int unsigned P = 4 + 64 + 3;
`ifdef PUF_MAJORITY_EN
  localparam int unsigned NV = 3;
`else
  localparam int unsigned NV = 1;
`endif
  localparam int unsigned RUN = 8 * P * NV;

  typedef struct {
    logic [7:0] resp;
    logic       sat;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ro_puf_serial_engine_if #(.CHAL_W(8), .RESP_W(8)) hif ();
  ro_puf_serial_engine_if #(.CHAL_W(8), .RESP_W(8)) hif2 ();

  logic       ro_a, ro_b, ro_en, ro_en2;
  logic [4:0] sel_a, sel_b, sel_a2, sel_b2;
  logic       fast_ro = 1'b0, slow_ro = 1'b0, p2_ro = 1'b0;
  logic [31:0] lut = '0;
  logic       inv_odd = 1'b0;
  logic       flip;
  int         meas_cnt = 0;
  int         cyc = 0;
  int         start_cyc = 0, start_cyc2 = 0;
  int         n_checks = 0, n_err = 0;

  logic [9:0] sel_q[$];
  exp_t       exp_q[$];
  exp_t       exp2_q[$];

  // Behavioural oscillators: periods of 3, 5 and 2 clocks, phased away from clock edges.
  initial begin #2; forever #15 fast_ro = ~fast_ro; end
  initial begin #4; forever #25 slow_ro = ~slow_ro; end
  initial begin #3; forever #10 p2_ro = ~p2_ro; end

  assign flip = inv_odd && (((meas_cnt - 1) % NV) == 1);
  assign ro_a = (lut[sel_a] ^ flip) ? fast_ro : slow_ro;
  assign ro_b = (lut[sel_a] ^ flip) ? slow_ro : fast_ro;

  ro_puf_serial_engine #(.SETTLE_CYCLES(4), .WINDOW_CYCLES(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .host     (hif.slave),
    .ro_a_in  (ro_a),
    .ro_b_in  (ro_b),
    .ro_en    (ro_en),
    .ro_sel_a (sel_a),
    .ro_sel_b (sel_b)
  );

  ro_puf_serial_engine #(.CNT_W(4), .SETTLE_CYCLES(4), .WINDOW_CYCLES(64)) dut_sat (
    .clk      (clk),
    .rst      (rst),
    .host     (hif2.slave),
    .ro_a_in  (p2_ro),
    .ro_b_in  (p2_ro),
    .ro_en    (ro_en2),
    .ro_sel_a (sel_a2),
    .ro_sel_b (sel_b2)
  );

  initial forever begin @(posedge clk); cyc++; end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Monitor: selects on each measurement start, result on each done rising edge.
  initial begin
    logic en_prev = 1'b0, done_prev = 1'b0, done2_prev = 1'b0;
    logic [9:0] s;
    exp_t e;
    forever begin
      @(negedge clk);
      if (ro_en && !en_prev) begin
        meas_cnt++;
        if (sel_q.size() == 0) check("sel_unexpected", {22'd0, sel_a, sel_b}, 32'hFFFF_FFFF);
        else begin
          s = sel_q.pop_front();
          check("sel_pair", {22'd0, sel_a, sel_b}, {22'd0, s});
        end
      end
      en_prev = ro_en;
      if (hif.done && !done_prev) begin
        if (exp_q.size() == 0) check("done_unexpected", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("response", {24'd0, hif.response}, {24'd0, e.resp});
          check("sat", {31'd0, hif.sat}, {31'd0, e.sat});
          check("latency", cyc - start_cyc, e.lat);
        end
      end
      done_prev = hif.done;
      if (hif2.done && !done2_prev) begin
        if (exp2_q.size() == 0) check("done2_unexpected", 32'd1, 32'd0);
        else begin
          e = exp2_q.pop_front();
          check("sat_response", {24'd0, hif2.response}, {24'd0, e.resp});
          check("sat_flag", {31'd0, hif2.sat}, {31'd0, e.sat});
          check("sat_latency", cyc - start_cyc2, e.lat);
        end
      end
      done2_prev = hif2.done;
    end
  end

  task automatic start_run(input logic [7:0] chal, input int n_pairs);
    logic [4:0] a;
    for (int i = 0; i < n_pairs; i++) begin
      a = chal[4:0] + 5'(2 * i);
      for (int v = 0; v < NV; v++) sel_q.push_back({a, a + 5'd1});
    end
    @(negedge clk);
    hif.start = 1'b1;
    hif.challenge = chal;
    meas_cnt = 0;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    hif.start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit ok = 1'b0;
    for (int k = 0; k < RUN + 100; k++) begin
      @(negedge clk);
      if (hif.done) begin ok = 1'b1; break; end
    end
    if (!ok) check(nm, 32'd0, 32'd1);
  endtask

  task automatic do_ack(input logic [7:0] resp);
    @(negedge clk);
    hif.ack = 1'b1;
    @(posedge clk);
    #1;
    check("ack_busy", {31'd0, hif.busy}, 32'd0);
    check("ack_done", {31'd0, hif.done}, 32'd0);
    check("ack_resp", {24'd0, hif.response}, {24'd0, resp});
    hif.ack = 1'b0;
  endtask

  task automatic check_reset(input string nm);
    check({nm, "_busy"}, {31'd0, hif.busy}, 32'd0);
    check({nm, "_done"}, {31'd0, hif.done}, 32'd0);
    check({nm, "_ro_en"}, {31'd0, ro_en}, 32'd0);
    check({nm, "_resp"}, {24'd0, hif.response}, 32'd0);
    check({nm, "_sat"}, {31'd0, hif.sat}, 32'd0);
    check({nm, "_sel"}, {22'd0, sel_a, sel_b}, 32'd0);
  endtask

  initial begin
    bit ok;
    rst = 1'b1;
    hif.start = 1'b0; hif.challenge = '0; hif.ack = 1'b0;
    hif2.start = 1'b0; hif2.challenge = '0; hif2.ack = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst = 1'b0;

    // Reset in the middle of the first MEASURE window.
    lut = '1;
    start_run(8'h00, 1);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset("midrun");
    @(negedge clk);
    rst = 1'b0;

    // Bias: A always faster; ack and a new start during the run must be ignored.
    exp_q.push_back('{resp: 8'hFF, sat: 1'b0, lat: RUN});
    start_run(8'h00, 8);
    repeat (10) @(negedge clk);
    hif.ack = 1'b1;
    @(negedge clk);
    hif.ack = 1'b0;
    hif.start = 1'b1; hif.challenge = 8'h55;
    @(negedge clk);
    hif.start = 1'b0;
    wait_done("timeout_bias");
    do_ack(8'hFF);

    // B always faster.
    lut = '0;
    exp_q.push_back('{resp: 8'h00, sat: 1'b0, lat: RUN});
    start_run(8'h00, 8);
    wait_done("timeout_bfast");
    do_ack(8'h00);

    // Per-oscillator pattern with wrap-around selects (30/31, 0/1, 2/3 ... 12/13).
    lut = 32'hA5C3_0F96;
    exp_q.push_back('{resp: 8'h6C, sat: 1'b0, lat: RUN});
    start_run(8'h1E, 8);
    wait_done("timeout_wrap");
    // Handshake: ack withheld for 100 cycles, start pulsed mid-way must not restart.
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      check("hold_done", {31'd0, hif.done}, 32'd1);
      check("hold_resp", {24'd0, hif.response}, 32'h6C);
      if (k == 50) begin hif.start = 1'b1; hif.challenge = 8'h33; end
      if (k == 51) hif.start = 1'b0;
    end
    do_ack(8'h6C);
    repeat (5) @(negedge clk);
    check("idle_resp", {24'd0, hif.response}, 32'h6C);
    check("idle_busy", {31'd0, hif.busy}, 32'd0);

`ifdef PUF_MAJORITY_EN
    // A faster on votes 0 and 2 only: every bit still resolves to 1.
    lut = '1;
    inv_odd = 1'b1;
    exp_q.push_back('{resp: 8'hFF, sat: 1'b0, lat: RUN});
    start_run(8'h00, 8);
    wait_done("timeout_vote");
    do_ack(8'hFF);
    inv_odd = 1'b0;
`endif

    // Saturation and tie on the 4-bit-counter instance.
    exp2_q.push_back('{resp: 8'h00, sat: 1'b1, lat: RUN});
    @(negedge clk);
    hif2.start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc2 = cyc;
    hif2.start = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < RUN + 100; k++) begin
      @(negedge clk);
      if (hif2.done) begin ok = 1'b1; break; end
    end
    if (!ok) check("timeout_sat", 32'd0, 32'd1);
    repeat (2) @(negedge clk);

    check("sel_queue_empty", sel_q.size(), 32'd0);
    check("exp_queue_empty", exp_q.size() + exp2_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
